// File: rtl/codec_pkg.sv
// codec_pkg: shared FSM encoding and limits for the codec init sequencer.
// Retry behaviour is enabled in the sequencer by defining CODEC_INIT_RETRY_EN.
package codec_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, SETTLE, DONE, ERROR} state_t;
    localparam int WD_LIMIT = 8;
    localparam int RETRY_LIMIT = 3;
    localparam logic [7:0] DEF_DEV_ADDR = 8'b0100_1100;
endpackage

// File: rtl/codec_init_rom.sv
// codec_init_rom: index -> {data_0, data_1}; data_0 = {reg[6:0], data[8]}, data_1 = data[7:0].
module codec_init_rom (
    input  logic [3:0]  i_index,
    output logic [15:0] o_entry
);
    always_comb begin
        o_entry = 16'h0000;
        case (i_index)
            4'd0: o_entry = 16'h1E00; // reset
            4'd1: o_entry = 16'h0C10; // power: everything up except outputs
            4'd2: o_entry = 16'h0017;
            4'd3: o_entry = 16'h0217;
            4'd4: o_entry = 16'h0812;
            4'd5: o_entry = 16'h0A00;
            4'd6: o_entry = 16'h0E42; // interface: master, I2S, 16-bit
            4'd7: o_entry = 16'h1000; // sample rate: normal mode, 48 kHz
            4'd8: o_entry = 16'h1201; // activate
            4'd9: o_entry = 16'h0C00; // power: outputs on
            default: o_entry = 16'h0000;
        endcase
    end
endmodule

// File: rtl/codec_init_sequencer.sv
// codec_init_sequencer: walks the codec init ROM, issuing one i2c write per entry.
// Define CODEC_INIT_RETRY_EN to retry a NACKed or unacknowledged write up to 3 times.
module codec_init_sequencer
    import codec_pkg::*;
#(
    parameter int NUM_WRITES = 10,
    parameter logic [7:0] DEV_ADDR = DEF_DEV_ADDR,
    parameter int SETTLE_CYCLES = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    output logic       i2c_start,
    output logic [7:0] i2c_cmd_address,
    output logic [7:0] i2c_data_0,
    output logic [7:0] i2c_data_1,
    input  logic       i2c_busy,
    input  logic       i2c_nack,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] index
);
    localparam logic [3:0] LAST = 4'(NUM_WRITES - 1);
    localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_CYCLES == 0 ? 0 : SETTLE_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_index;
    logic [9:0]  r_settle;
    logic [2:0]  r_wd;
    logic        r_start, r_busy, r_done, r_error;
    logic        w_can_retry;
    logic [15:0] w_entry;

    codec_init_rom u_rom (.i_index(r_index), .o_entry(w_entry));

`ifdef CODEC_INIT_RETRY_EN
    logic [1:0] r_retry;
    logic       w_fault;
    assign w_fault = !i2c_busy && ((r_state == WAIT_ACK && r_wd == 3'(WD_LIMIT - 1)) ||
                                   (r_state == WAIT_DONE && i2c_nack));
    assign w_can_retry = r_retry != 2'(RETRY_LIMIT);
    // Per-entry budget: cleared whenever a fresh entry or sequence is about to start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_retry <= '0;
        else if (w_fault && w_can_retry)
            r_retry <= r_retry + 2'd1;
        else if (r_state inside {IDLE, SETTLE, DONE, ERROR})
            r_retry <= '0;
    end
`else
    assign w_can_retry = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_index  <= '0;
            r_settle <= '0;
            r_wd     <= '0;
            r_start  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                IDLE, DONE, ERROR: if (go) begin
                    r_state <= ISSUE;
                    r_index <= '0;
                    r_start <= 1'b1;
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                    r_error <= 1'b0;
                end
                ISSUE: begin
                    r_state <= WAIT_ACK;
                    r_wd    <= 3'd1;
                end
                WAIT_ACK: if (i2c_busy) begin
                    r_state <= WAIT_DONE;
                    r_wd    <= '0;
                end else if (r_wd == 3'(WD_LIMIT - 1)) begin
                    r_state <= w_can_retry ? ISSUE : ERROR;
                    r_start <= w_can_retry;
                    r_busy  <= w_can_retry;
                    r_error <= !w_can_retry;
                    r_wd    <= '0;
                end else
                    r_wd <= r_wd + 3'd1;
                WAIT_DONE: if (!i2c_busy) begin
                    if (i2c_nack) begin
                        r_state <= w_can_retry ? ISSUE : ERROR;
                        r_start <= w_can_retry;
                        r_busy  <= w_can_retry;
                        r_error <= !w_can_retry;
                    end else if (r_index == LAST) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state  <= SETTLE;
                        r_settle <= '0;
                    end
                end
                SETTLE: if (r_settle == SETTLE_LAST) begin
                    r_state  <= ISSUE;
                    r_index  <= r_index + 4'd1;
                    r_start  <= 1'b1;
                    r_settle <= '0;
                end else
                    r_settle <= r_settle + 10'd1;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign i2c_start       = r_start;
    assign i2c_cmd_address = DEV_ADDR;
    assign i2c_data_0      = w_entry[15:8];
    assign i2c_data_1      = w_entry[7:0];
    assign busy            = r_busy;
    assign done            = r_done;
    assign error           = r_error;
    assign index           = r_index;
endmodule

// File: tb/tb_codec_init_sequencer.sv
// tb_codec_init_sequencer: directed checks of the init sequencer against a simple i2c controller model.
module tb_codec_init_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go = 1'b0;
    logic       i2c_start, i2c_busy, i2c_nack, busy, done, error;
    logic [7:0] i2c_cmd_address, i2c_data_0, i2c_data_1;
    logic [3:0] index;

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    int starts = 0;
    int mcnt = 0;
    int nack_at = 0;
    bit silent = 1'b0;
    bit nack_en = 1'b0;
    int start_q[$];
    logic [15:0] data_q[$];

    codec_init_sequencer #(.NUM_WRITES(3), .DEV_ADDR(8'h4C), .SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .go(go), .i2c_start(i2c_start), .i2c_cmd_address(i2c_cmd_address),
        .i2c_data_0(i2c_data_0), .i2c_data_1(i2c_data_1), .i2c_busy(i2c_busy), .i2c_nack(i2c_nack),
        .busy(busy), .done(done), .error(error), .index(index)
    );

    always #5 clk = ~clk;

    // Controller model: busy rises with the start pulse and stays up for 20 cycles.
    assign i2c_busy = !silent && (i2c_start || mcnt != 0);
    assign i2c_nack = nack_en && starts >= nack_at;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) mcnt <= 0;
        else if (i2c_start && !silent) mcnt <= 19;
        else if (mcnt > 0) mcnt <= mcnt - 1;
        if (i2c_start) begin
            starts <= starts + 1;
            start_q.push_back(cyc);
            data_q.push_back({i2c_data_0, i2c_data_1});
        end
    end

    function automatic logic [15:0] exp_entry(input int i);
        case (i)
            0: return 16'h1E00;
            1: return 16'h0C10;
            2: return 16'h0017;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic pulse_go();
        @(negedge clk) go = 1'b1;
        @(negedge clk) go = 1'b0;
    endtask

    task automatic wait_end(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            if (done || error) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        int base;
        @(negedge clk);
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_assert++; if (done !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL reset_flags got done=%b error=%b exp 0/0", done, error); end
        n_assert++; if (index !== 4'd0 || i2c_start !== 1'b0) begin n_fail++; $display("FAIL reset_idx_start got %0d/%b exp 0/0", index, i2c_start); end
        n_assert++; if ({i2c_data_0, i2c_data_1} !== exp_entry(0)) begin n_fail++; $display("FAIL reset_data got %h exp %h", {i2c_data_0, i2c_data_1}, exp_entry(0)); end
        n_assert++; if (i2c_cmd_address !== 8'h4C) begin n_fail++; $display("FAIL dev_addr got %h exp 4c", i2c_cmd_address); end
        rst = 1'b0;
        base = starts;
        repeat (15) @(negedge clk);
        n_assert++; if (starts !== base) begin n_fail++; $display("FAIL start_without_go got %0d exp %0d", starts, base); end
    endtask

    task automatic test_sequence();
        int base;
        bit ok;
        base = starts;
        pulse_go();
        n_assert++; if (i2c_start !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL go_latency got start=%b busy=%b exp 1/1", i2c_start, busy); end
        wait_end(300, ok);
        n_assert++; if (!ok) begin n_fail++; $display("FAIL seq_timeout got done=%b exp 1", done); end
        n_assert++; if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL seq_flags got d=%b e=%b b=%b exp 1/0/0", done, error, busy); end
        n_assert++; if (index !== 4'd2) begin n_fail++; $display("FAIL seq_index got %0d exp 2", index); end
        n_assert++; if (starts - base !== 3) begin n_fail++; $display("FAIL seq_starts got %0d exp 3", starts - base); end
        for (int i = 0; i < 3 && base + i < start_q.size(); i++) begin
            n_assert++; if (data_q[base + i] !== exp_entry(i)) begin n_fail++; $display("FAIL seq_data%0d got %h exp %h", i, data_q[base + i], exp_entry(i)); end
        end
        for (int i = 1; i < 3 && base + i < start_q.size(); i++) begin
            n_assert++; if (start_q[base + i] - start_q[base + i - 1] !== 25) begin n_fail++; $display("FAIL seq_gap%0d got %0d exp 25", i, start_q[base + i] - start_q[base + i - 1]); end
        end
        repeat (10) @(negedge clk);
        n_assert++; if (starts - base !== 3 || done !== 1'b1) begin n_fail++; $display("FAIL done_hold got starts=%0d done=%b exp 3/1", starts - base, done); end
    endtask

    task automatic test_nack();
        int base, exp_n;
        bit ok;
`ifdef CODEC_INIT_RETRY_EN
        exp_n = 5;
`else
        exp_n = 2;
`endif
        base = starts;
        nack_at = base + 2;
        nack_en = 1'b1;
        pulse_go();
        n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL go_clears_done got %b exp 0", done); end
        wait_end(400, ok);
        n_assert++; if (!ok) begin n_fail++; $display("FAIL nack_timeout got error=%b exp 1", error); end
        n_assert++; if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL nack_flags got e=%b d=%b b=%b exp 1/0/0", error, done, busy); end
        n_assert++; if (index !== 4'd1) begin n_fail++; $display("FAIL nack_index got %0d exp 1", index); end
        n_assert++; if (starts - base !== exp_n) begin n_fail++; $display("FAIL nack_starts got %0d exp %0d", starts - base, exp_n); end
        nack_en = 1'b0;
    endtask

    task automatic test_watchdog();
        int base, k, exp_k, exp_n;
`ifdef CODEC_INIT_RETRY_EN
        exp_k = 32; exp_n = 4;
`else
        exp_k = 8; exp_n = 1;
`endif
        silent = 1'b1;
        base = starts;
        pulse_go();
        n_assert++; if (error !== 1'b0 || i2c_start !== 1'b1) begin n_fail++; $display("FAIL wd_restart got e=%b s=%b exp 0/1", error, i2c_start); end
        k = 0;
        while (!error && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_assert++; if (k !== exp_k) begin n_fail++; $display("FAIL wd_latency got %0d exp %0d", k, exp_k); end
        n_assert++; if (starts - base !== exp_n || index !== 4'd0) begin n_fail++; $display("FAIL wd_starts got %0d idx %0d exp %0d idx 0", starts - base, index, exp_n); end
        silent = 1'b0;
    endtask

    task automatic test_go_ignored();
        int base;
        bit ok;
        base = starts;
        pulse_go();
        repeat (21) @(negedge clk);
        n_assert++; if (busy !== 1'b1 || i2c_busy !== 1'b0) begin n_fail++; $display("FAIL in_settle got b=%b ib=%b exp 1/0", busy, i2c_busy); end
        go = 1'b1;
        @(negedge clk) go = 1'b0;
        wait_end(300, ok);
        n_assert++; if (!ok || done !== 1'b1 || index !== 4'd2) begin n_fail++; $display("FAIL settle_go got done=%b idx=%0d exp 1/2", done, index); end
        n_assert++; if (starts - base !== 3) begin n_fail++; $display("FAIL settle_go_starts got %0d exp 3", starts - base); end
        n_assert++; if (start_q.size() >= base + 2 && start_q[base + 1] - start_q[base] !== 25) begin n_fail++; $display("FAIL settle_go_gap got %0d exp 25", start_q[base + 1] - start_q[base]); end
        pulse_go();
        n_assert++; if (done !== 1'b0 || index !== 4'd0 || i2c_start !== 1'b1) begin n_fail++; $display("FAIL go_in_done got d=%b i=%0d s=%b exp 0/0/1", done, index, i2c_start); end
        wait_end(300, ok);
        n_assert++; if (!ok || done !== 1'b1) begin n_fail++; $display("FAIL rerun_done got %b exp 1", done); end
    endtask

    task automatic test_reset_mid();
        int base, k;
        base = starts;
        pulse_go();
        k = 0;
        while (starts != base + 3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (5) @(negedge clk);
        n_assert++; if (busy !== 1'b1 || index !== 4'd2 || i2c_busy !== 1'b1) begin n_fail++; $display("FAIL pre_rst got b=%b i=%0d ib=%b exp 1/2/1", busy, index, i2c_busy); end
        #2 rst = 1'b1;
        #1;
        n_assert++; if (busy !== 1'b0 || index !== 4'd0 || i2c_start !== 1'b0) begin n_fail++; $display("FAIL async_rst got b=%b i=%0d s=%b exp 0/0/0", busy, index, i2c_start); end
        n_assert++; if ({i2c_data_0, i2c_data_1} !== exp_entry(0) || done !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL async_rst_data got %h d=%b e=%b exp %h/0/0", {i2c_data_0, i2c_data_1}, done, error, exp_entry(0)); end
        @(negedge clk) rst = 1'b0;
        repeat (40) @(negedge clk);
        n_assert++; if (starts !== base + 3 || busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle got starts=%0d b=%b exp %0d/0", starts - base, busy, 3); end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_nack();
        test_watchdog();
        test_go_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
